// File: rtl/stream_upsizer.sv
// Width up-converter: packs P_RATIO narrow beats into one wide word.
// An early s_last flushes a zero-padded partial word with a lane keep mask.
module stream_upsizer #(
    parameter int P_WIDTH = 8,
    parameter int P_RATIO = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [P_WIDTH-1:0]           s_data,
    input  logic                         s_last,
    input  logic                         s_vld,
    output logic                         s_rdy,
    output logic [P_WIDTH*P_RATIO-1:0]   m_data,
    output logic [P_RATIO-1:0]           m_keep,
    output logic                         m_last,
    output logic                         m_vld,
    input  logic                         m_rdy
);

    localparam int CNT_BITS = $clog2(P_RATIO);
    localparam int OUT_W    = P_WIDTH * P_RATIO;
    localparam int ACC_W    = P_WIDTH * (P_RATIO - 1);

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(P_RATIO - 1);

    logic [CNT_BITS-1:0] cnt;
    logic [ACC_W-1:0]    acc;
    logic [P_RATIO-2:0]  acc_keep;

    logic                accept;
    logic                complete;
    logic [OUT_W-1:0]    word_nxt;
    logic [P_RATIO-1:0]  keep_nxt;

    // Upstream may push whenever the output slot is empty or draining now.
    assign s_rdy    = ~m_vld | m_rdy;
    assign accept   = s_vld & s_rdy;
    assign complete = accept & (s_last | (cnt == CNT_LAST));

    // Assemble the closing word: stored lanes plus the current beat in lane cnt.
    always_comb begin
        word_nxt = {{P_WIDTH{1'b0}}, acc};
        word_nxt[cnt*P_WIDTH +: P_WIDTH] = s_data;
        keep_nxt = {1'b0, acc_keep};
        keep_nxt[cnt] = 1'b1;
    end

    // Accumulator fill and output register slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            acc_keep <= '0;
            m_data   <= '0;
            m_keep   <= '0;
            m_last   <= 1'b0;
            m_vld    <= 1'b0;
        end else begin
            if (m_vld && m_rdy) begin
                m_vld <= 1'b0;
            end
            if (complete) begin
                m_data   <= word_nxt;
                m_keep   <= keep_nxt;
                m_last   <= s_last;
                m_vld    <= 1'b1;
                cnt      <= '0;
                acc      <= '0;
                acc_keep <= '0;
            end else if (accept) begin
                acc[cnt*P_WIDTH +: P_WIDTH] <= s_data;
                acc_keep[cnt]               <= 1'b1;
                cnt                         <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_upsizer.sv
// Directed testbench for stream_upsizer (P_WIDTH=8, P_RATIO=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_stream_upsizer;

    logic        clk;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_vld;
    logic        s_rdy;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic        m_vld;
    logic        m_rdy;

    int vec;
    int err;

    stream_upsizer #(
        .P_WIDTH(8),
        .P_RATIO(4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .s_data(s_data),
        .s_last(s_last),
        .s_vld (s_vld),
        .s_rdy (s_rdy),
        .m_data(m_data),
        .m_keep(m_keep),
        .m_last(m_last),
        .m_vld (m_vld),
        .m_rdy (m_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        s_data = d;
        s_last = l;
        s_vld  = 1'b1;
        while (!s_rdy && n < 20) begin
            tick();
            n++;
        end
        if (!s_rdy) begin
            vec++;
            err++;
            $display("FAIL beat_timeout s_rdy=%b want 1", s_rdy);
        end else begin
            tick();
        end
    endtask

    task automatic idle();
        s_vld  = 1'b0;
        s_last = 1'b0;
        s_data = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        vec++;
        if (m_vld !== 1'b0) begin
            err++;
            $display("FAIL reset_m_vld got %b want 0", m_vld);
        end
        vec++;
        if (m_keep !== 4'h0) begin
            err++;
            $display("FAIL reset_m_keep got %h want 0", m_keep);
        end
        vec++;
        if (m_data !== 32'h0) begin
            err++;
            $display("FAIL reset_m_data got %h want 0", m_data);
        end
        vec++;
        if (m_last !== 1'b0) begin
            err++;
            $display("FAIL reset_m_last got %b want 0", m_last);
        end
        vec++;
        if (s_rdy !== 1'b1) begin
            err++;
            $display("FAIL reset_s_rdy got %b want 1", s_rdy);
        end
    endtask

    task automatic test_full_word();
        m_rdy = 1'b1;
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0);
        vec++;
        if (m_vld !== 1'b0) begin
            err++;
            $display("FAIL full_early_vld got %b want 0", m_vld);
        end
        beat(8'h44, 1'b0);
        idle();
        vec++;
        if (m_vld !== 1'b1 || m_data !== 32'h44332211) begin
            err++;
            $display("FAIL full_data got vld=%b %h want 1 44332211",
                     m_vld, m_data);
        end
        vec++;
        if (m_keep !== 4'hF || m_last !== 1'b0) begin
            err++;
            $display("FAIL full_keep got keep=%h last=%b want F 0",
                     m_keep, m_last);
        end
        tick();
        vec++;
        if (m_vld !== 1'b0) begin
            err++;
            $display("FAIL full_pulse got vld=%b want 0", m_vld);
        end
    endtask

    task automatic test_partial();
        m_rdy = 1'b1;
        beat(8'hA1, 1'b0);
        beat(8'hA2, 1'b1);
        idle();
        vec++;
        if (m_vld !== 1'b1 || m_data !== 32'h0000A2A1) begin
            err++;
            $display("FAIL partial_data got vld=%b %h want 1 0000A2A1",
                     m_vld, m_data);
        end
        vec++;
        if (m_keep !== 4'b0011 || m_last !== 1'b1) begin
            err++;
            $display("FAIL partial_keep got keep=%b last=%b want 0011 1",
                     m_keep, m_last);
        end
        beat(8'hB1, 1'b1);
        idle();
        vec++;
        if (m_data !== 32'h000000B1 || m_keep !== 4'b0001
            || m_last !== 1'b1) begin
            err++;
            $display("FAIL single_lane got %h keep=%b last=%b want 000000B1 0001 1",
                     m_data, m_keep, m_last);
        end
        beat(8'hC1, 1'b0);
        beat(8'hC2, 1'b0);
        beat(8'hC3, 1'b0);
        beat(8'hC4, 1'b1);
        idle();
        vec++;
        if (m_data !== 32'hC4C3C2C1 || m_keep !== 4'hF
            || m_last !== 1'b1) begin
            err++;
            $display("FAIL last_full got %h keep=%h last=%b want C4C3C2C1 F 1",
                     m_data, m_keep, m_last);
        end
        tick();
    endtask

    task automatic test_backpressure();
        m_rdy = 1'b0;
        beat(8'h10, 1'b0);
        beat(8'h20, 1'b0);
        beat(8'h30, 1'b0);
        beat(8'h40, 1'b0);
        s_data = 8'h99;
        s_last = 1'b0;
        s_vld  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            vec++;
            if (s_rdy !== 1'b0 || m_vld !== 1'b1
                || m_data !== 32'h40302010) begin
                err++;
                $display("FAIL hold_%0d got s_rdy=%b vld=%b %h want 0 1 40302010",
                         i, s_rdy, m_vld, m_data);
            end
            tick();
        end
        m_rdy = 1'b1;
        #1;
        vec++;
        if (s_rdy !== 1'b1) begin
            err++;
            $display("FAIL release_s_rdy got %b want 1", s_rdy);
        end
        tick();
        vec++;
        if (m_vld !== 1'b0) begin
            err++;
            $display("FAIL release_drain got vld=%b want 0", m_vld);
        end
        beat(8'h98, 1'b0);
        beat(8'h97, 1'b0);
        beat(8'h96, 1'b0);
        idle();
        vec++;
        if (m_vld !== 1'b1 || m_data !== 32'h96979899
            || m_keep !== 4'hF) begin
            err++;
            $display("FAIL after_hold got vld=%b %h keep=%h want 1 96979899 F",
                     m_vld, m_data, m_keep);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        m_rdy = 1'b0;
        beat(8'hE1, 1'b1);
        s_data = 8'hF1;
        s_last = 1'b1;
        s_vld  = 1'b1;
        tick();
        vec++;
        if (m_vld !== 1'b1 || m_data !== 32'h000000E1) begin
            err++;
            $display("FAIL b2b_held got vld=%b %h want 1 000000E1",
                     m_vld, m_data);
        end
        m_rdy = 1'b1;
        tick();
        idle();
        vec++;
        if (m_vld !== 1'b1 || m_data !== 32'h000000F1
            || m_keep !== 4'b0001) begin
            err++;
            $display("FAIL b2b_swap got vld=%b %h keep=%b want 1 000000F1 0001",
                     m_vld, m_data, m_keep);
        end
        tick();
        vec++;
        if (m_vld !== 1'b0) begin
            err++;
            $display("FAIL b2b_drain got vld=%b want 0", m_vld);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] exp_q[$];
        logic [31:0] w;
        int          got;
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h08070605);
        got   = 0;
        m_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_data = 8'(i + 1);
            s_last = 1'b0;
            s_vld  = 1'b1;
            vec++;
            if (s_rdy !== 1'b1) begin
                err++;
                $display("FAIL stream_rdy_%0d got %b want 1", i, s_rdy);
            end
            tick();
            vec++;
            if (m_vld !== ((i % 4) == 3)) begin
                err++;
                $display("FAIL stream_vld_%0d got %b want %b",
                         i, m_vld, ((i % 4) == 3));
            end
            if (m_vld === 1'b1) begin
                got++;
                w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
                vec++;
                if (m_data !== w || m_keep !== 4'hF) begin
                    err++;
                    $display("FAIL stream_word got %h keep=%h want %h F",
                             m_data, m_keep, w);
                end
            end
        end
        idle();
        tick();
        vec++;
        if (got != 2 || exp_q.size() != 0) begin
            err++;
            $display("FAIL stream_count got %0d words want 2", got);
        end
    endtask

    task automatic test_reset_mid_word();
        m_rdy = 1'b1;
        beat(8'h5A, 1'b0);
        beat(8'h5B, 1'b0);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        beat(8'h55, 1'b0);
        beat(8'h66, 1'b0);
        beat(8'h77, 1'b0);
        beat(8'h88, 1'b0);
        idle();
        vec++;
        if (m_vld !== 1'b1 || m_data !== 32'h88776655
            || m_keep !== 4'hF) begin
            err++;
            $display("FAIL reset_mid got vld=%b %h keep=%h want 1 88776655 F",
                     m_vld, m_data, m_keep);
        end
        tick();
    endtask

    initial begin
        vec    = 0;
        err    = 0;
        rst    = 1'b1;
        s_data = 8'h00;
        s_last = 1'b0;
        s_vld  = 1'b0;
        m_rdy  = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_word();
        test_partial();
        test_backpressure();
        test_back_to_back();
        test_streaming();
        test_reset_mid_word();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
